// File: rtl/alu_seq_ctrl_if.sv
// Interface for the ALU sequencing controller.
// It carries the button levels in, and the datapath strobes and status out.
interface alu_seq_ctrl_if;
  logic       enter;
  logic       undo;
  logic       load_A;
  logic       load_B;
  logic       load_Op;
  logic       updateRes;
  logic [2:0] state_o;
  logic       result_valid;
  logic       timeout_o;

  modport slave (
    input  enter, undo,
    output load_A, load_B, load_Op, updateRes, state_o, result_valid, timeout_o
  );

  modport master (
    output enter, undo,
    input  load_A, load_B, load_Op, updateRes, state_o, result_valid, timeout_o
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: turns enter/undo button edges into the A, B, Op and result load strobes.
// Optional idle auto-return to WAIT_A is enabled by defining IDLE_TIMEOUT_EN.
module alu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   enterPrev_q, undoPrev_q;
  logic   loadA_q, loadA_d;
  logic   loadB_q, loadB_d;
  logic   loadOp_q, loadOp_d;
  logic   updateRes_q, updateRes_d;
  logic   resultValid_q;
  logic   enterEdge, undoEdge, enterOnly, undoOnly;
  logic   timeoutHit;

  assign enterEdge = bus.enter & ~enterPrev_q;
  assign undoEdge  = bus.undo & ~undoPrev_q;
  assign enterOnly = enterEdge & ~undoEdge;
  assign undoOnly  = undoEdge & ~enterEdge;

`ifdef IDLE_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] idleCnt_q, idleCnt_d;
  logic            timeout_q;
  logic            counting;

  assign counting   = (state_q == WAIT_B) || (state_q == WAIT_OP) || (state_q == SHOW);
  assign timeoutHit = counting && !enterEdge && !undoEdge &&
                      (idleCnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Any edge, even a discarded simultaneous pair, counts as activity.
  always_comb begin
    idleCnt_d = '0;
    if (counting && !enterEdge && !undoEdge && (state_d == state_q))
      idleCnt_d = idleCnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      idleCnt_q <= idleCnt_d;
      timeout_q <= timeoutHit;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  // The parameter has no effect in this build; the comparison is a constant 0.
  assign timeoutHit    = (TIMEOUT_CYCLES < 0);
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    loadA_d     = 1'b0;
    loadB_d     = 1'b0;
    loadOp_d    = 1'b0;
    updateRes_d = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (enterOnly) begin
          state_d = WAIT_B;
          loadA_d = 1'b1;
        end
      end
      WAIT_B: begin
        if (timeoutHit) state_d = WAIT_A;
        else if (enterOnly) begin
          state_d = WAIT_OP;
          loadB_d = 1'b1;
        end else if (undoOnly) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (timeoutHit) state_d = WAIT_A;
        else if (enterOnly) begin
          state_d  = CALC;
          loadOp_d = 1'b1;
        end else if (undoOnly) state_d = WAIT_B;
      end
      CALC: begin
        state_d     = SHOW;
        updateRes_d = 1'b1;
      end
      SHOW: begin
        if (timeoutHit) state_d = WAIT_A;
        else if (enterOnly) state_d = WAIT_A;
        else if (undoOnly) state_d = WAIT_OP;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // History registers reset to 1 so that a button held through reset does not fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_A;
      enterPrev_q   <= 1'b1;
      undoPrev_q    <= 1'b1;
      loadA_q       <= 1'b0;
      loadB_q       <= 1'b0;
      loadOp_q      <= 1'b0;
      updateRes_q   <= 1'b0;
      resultValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      enterPrev_q   <= bus.enter;
      undoPrev_q    <= bus.undo;
      loadA_q       <= loadA_d;
      loadB_q       <= loadB_d;
      loadOp_q      <= loadOp_d;
      updateRes_q   <= updateRes_d;
      resultValid_q <= (state_d == SHOW);
    end
  end

  assign bus.load_A       = loadA_q;
  assign bus.load_B       = loadB_q;
  assign bus.load_Op      = loadOp_q;
  assign bus.updateRes    = updateRes_q;
  assign bus.state_o      = state_q;
  assign bus.result_valid = resultValid_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a table-driven reference model is compared every cycle,
// with directed scenarios, literal expectations and randomized button activity.
module tb_alu_seq_ctrl;

  localparam int TO = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the successor of each state on an enter or undo edge is kept in a table.
  // Strobes are named after the (from, to) pair of a transition.
  int         enterNext [5] = '{1, 2, 3, 3, 0};
  int         undoNext  [5] = '{0, 0, 1, 3, 2};
  int         mState  = 0;
  bit         mPrevE  = 1'b1;
  bit         mPrevU  = 1'b1;
  int         mIdle   = 0;
  bit         started = 1'b0;
  logic [8:0] expVec  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState  = 0;
      mPrevE  = 1'b1;
      mPrevU  = 1'b1;
      mIdle   = 0;
      expVec  = '0;
      started = 1'b1;
    end else begin : modelStep
      int fromS, toS;
      bit eE, uE, tmo;
      eE    = bus.enter && !mPrevE;
      uE    = bus.undo && !mPrevU;
      fromS = mState;
      toS   = mState;
      tmo   = 1'b0;
      if (fromS == 3) toS = 4;
      else if (eE && !uE) toS = enterNext[fromS];
      else if (uE && !eE) toS = undoNext[fromS];
`ifdef IDLE_TIMEOUT_EN
      if (toS == fromS && !eE && !uE && (fromS == 1 || fromS == 2 || fromS == 4)) begin
        mIdle++;
        if (mIdle == TO) begin
          toS   = 0;
          tmo   = 1'b1;
          mIdle = 0;
        end
      end else mIdle = 0;
`endif
      expVec = {3'(toS), (fromS == 0 && toS == 1), (fromS == 1 && toS == 2),
                (fromS == 2 && toS == 3), (fromS == 3 && toS == 4), (toS == 4), tmo};
      mState = toS;
      mPrevE = bus.enter;
      mPrevU = bus.undo;
    end
  end

  function automatic logic [8:0] dutVec();
    return {bus.state_o, bus.load_A, bus.load_B, bus.load_Op, bus.updateRes,
            bus.result_valid, bus.timeout_o};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual={st,lA,lB,lOp,uR,rv,to}=%b required=%b at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input int n);
    bus.enter = e;
    bus.undo  = u;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One compare per cycle, on the falling edge, once the first reset has been seen.
  always @(negedge clk) begin
    if (started) checkOutput("model_cycle", dutVec(), expVec);
  end

  initial begin : mainSeq
    logic eL, uL;
    bus.enter = 1'b1;
    bus.undo  = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("reset_values", dutVec(), 9'd0);
    applyStimulus(1, 0, 3);
    checkOutput("held_enter_no_fire", dutVec(), 9'd0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    checkOutput("load_A_after_rearm", dutVec(), {3'd1, 4'b1000, 1'b0, 1'b0});
    applyStimulus(1, 0, 3);
    checkOutput("load_A_one_cycle", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 4);
    applyStimulus(1, 0, 1);
    checkOutput("load_B", dutVec(), {3'd2, 4'b0100, 1'b0, 1'b0});
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 4);
    applyStimulus(1, 0, 1);
    checkOutput("load_Op_calc", dutVec(), {3'd3, 4'b0010, 1'b0, 1'b0});
    applyStimulus(1, 0, 1);
    checkOutput("updateRes_show", dutVec(), {3'd4, 4'b0001, 1'b1, 1'b0});
    applyStimulus(1, 0, 2);
    checkOutput("show_steady", dutVec(), {3'd4, 4'b0000, 1'b1, 1'b0});
    applyStimulus(0, 0, 4);

    applyStimulus(0, 1, 1);
    checkOutput("show_undo", dutVec(), {3'd2, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 1);
    checkOutput("reenter_op", dutVec(), {3'd3, 4'b0010, 1'b0, 1'b0});
    applyStimulus(0, 0, 1);
    checkOutput("reenter_update", dutVec(), {3'd4, 4'b0001, 1'b1, 1'b0});
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 1);
    checkOutput("show_enter_restart", dutVec(), 9'd0);
    applyStimulus(0, 0, 2);

    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    checkOutput("undo_op_to_b", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    checkOutput("undo_b_to_a", dutVec(), 9'd0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    checkOutput("undo_in_wait_a", dutVec(), 9'd0);
    applyStimulus(0, 0, 1);

    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("simultaneous_edges", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("calc_ignores_undo", dutVec(), {3'd4, 4'b0001, 1'b1, 1'b0});
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);

    applyStimulus(1, 0, 1);
    #1 reset = 1'b1;
    #1 checkOutput("async_reset_truncates", dutVec(), 9'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("reset_release_held", dutVec(), 9'd0);
    applyStimulus(0, 0, 1);

`ifdef IDLE_TIMEOUT_EN
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 9);
    checkOutput("before_timeout", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 1);
    checkOutput("timeout_pulse", dutVec(), {3'd0, 4'b0000, 1'b0, 1'b1});
    applyStimulus(0, 0, 1);
    checkOutput("timeout_one_cycle", dutVec(), 9'd0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 8);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 9);
    checkOutput("press_restarts_count", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 0, 1);
    checkOutput("timeout_after_restart", dutVec(), {3'd0, 4'b0000, 1'b0, 1'b1});
    applyStimulus(0, 0, 1);
`else
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 20);
    checkOutput("no_timeout_default", dutVec(), {3'd1, 4'b0000, 1'b0, 1'b0});
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
`endif

    eL = 1'b0;
    uL = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
      end else begin
        if ($urandom_range(0, 2) == 0) eL = ~eL;
        if ($urandom_range(0, 4) == 0) uL = ~uL;
        applyStimulus(eL, uL, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
